// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer and its helpers.
//   - coin values in cents (nickel/dime/quarter)
//   - coin codes carried on chg_coin
//   - sequencer FSM states
//   - product codes carried on disp_sel
package vend_pkg;

  localparam int NICKEL_VAL  = 5;
  localparam int DIME_VAL    = 10;
  localparam int QUARTER_VAL = 25;

  typedef enum logic [1:0] {
    COIN_NONE    = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_code_t;

  typedef enum logic [2:0] {
    IDLE,
    DISPENSE,
    CHG_REQ,
    CHG_GAP,
    DONE
  } state_t;

  localparam logic PROD_SODA = 1'b0;
  localparam logic PROD_DIET = 1'b1;

endpackage

// File: rtl/vend_sequencer_if.sv
// Actuator handshakes of the vending sequencer.
//   disp_req/disp_sel/disp_ack : dispenser motor request, product code, done
//   chg_req/chg_coin/chg_ack   : change hopper request, coin code, coin released
// master = sequencer side (drives requests), slave = actuator driver side.
interface vend_sequencer_if;
  import vend_pkg::*;

  logic       disp_req;
  logic       disp_sel;
  logic       disp_ack;
  logic       chg_req;
  coin_code_t chg_coin;
  logic       chg_ack;

  modport master (
    output disp_req, disp_sel, chg_req, chg_coin,
    input  disp_ack, chg_ack
  );

  modport slave (
    input  disp_req, disp_sel, chg_req, chg_coin,
    output disp_ack, chg_ack
  );

endinterface

// File: rtl/change_picker.sv
// Greedy change-coin selection. Purely combinational.
//   credit : amount still owed, in cents
//   coin   : largest coin not exceeding credit (nickel when below a dime)
//   value  : value of that coin in cents
// Credit is always a multiple of 5, so the nickel fallback never overpays.
module change_picker import vend_pkg::*; #(
  parameter int CREDIT_W = 7
) (
  input  logic [CREDIT_W-1:0] credit,
  output coin_code_t          coin,
  output logic [CREDIT_W-1:0] value
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    coin  = COIN_NICKEL;
    value = CREDIT_W'(NICKEL_VAL);
    if (credit >= CREDIT_W'(QUARTER_VAL)) begin
      coin  = COIN_QUARTER;
      value = CREDIT_W'(QUARTER_VAL);
    end else if (credit >= CREDIT_W'(DIME_VAL)) begin
      coin  = COIN_DIME;
      value = CREDIT_W'(DIME_VAL);
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Credit and dispense controller for the vending machine.
//   clk, reset_n          : clock, asynchronous active-low reset
//   nickel/dime/quarter   : one-cycle coin pulses
//   soda/diet             : product selection, sampled every cycle
//   coin_return           : refund current credit
//   hs (master)           : dispenser and change-hopper req/ack handshakes
//   credit                : current credit / remaining refund in cents
//   busy                  : high whenever not IDLE
//   coin_reject           : one-cycle pulse, coin sent to the return chute
//   vend_done             : one-cycle pulse at the end of a transaction
//   fault                 : one-cycle pulse on dispense timeout
module vend_sequencer import vend_pkg::*; #(
  parameter int PRICE        = 40,
  parameter int MAX_CREDIT   = 95,
  parameter int CREDIT_W     = 7,
  parameter int DISP_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                soda,
  input  logic                diet,
  input  logic                coin_return,
  vend_sequencer_if.master    hs,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                vend_done,
  output logic                fault
);

  localparam int TMO_W = $clog2(DISP_TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                sel_q, sel_d;
  logic                reject_q, reject_d;
  logic                fault_q, fault_d;

  // Coin decode: only a lone pulse can be credited.
  logic [1:0]          coin_cnt;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] coin_add;
  logic [CREDIT_W:0]   credit_plus;
  logic                coin_accept;
  logic                sel_valid;

  coin_code_t          pick_coin;
  logic [CREDIT_W-1:0] pick_val;

  assign coin_cnt = 2'(nickel) + 2'(dime) + 2'(quarter);

  always_comb begin
    coin_val = '0;
    if (nickel)  coin_val = CREDIT_W'(NICKEL_VAL);
    if (dime)    coin_val = CREDIT_W'(DIME_VAL);
    if (quarter) coin_val = CREDIT_W'(QUARTER_VAL);
  end

  // One extra bit so the range check cannot wrap.
  assign credit_plus = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_accept = (state_q == IDLE) && (coin_cnt == 2'd1) &&
                       (credit_plus <= (CREDIT_W+1)'(MAX_CREDIT));
  assign coin_add    = coin_accept ? coin_val : '0;

  // Selection looks at credit before this cycle's coin lands.
  assign sel_valid = (soda ^ diet) && (credit_q >= CREDIT_W'(PRICE));

  change_picker #(.CREDIT_W(CREDIT_W)) u_picker (
    .credit (credit_q),
    .coin   (pick_coin),
    .value  (pick_val)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      tmo_q    <= '0;
      sel_q    <= PROD_SODA;
      reject_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q  <= state_d;
      credit_q <= credit_d;
      tmo_q    <= tmo_d;
      sel_q    <= sel_d;
      reject_q <= reject_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    tmo_d    = tmo_q;
    sel_d    = sel_q;
    fault_d  = 1'b0;
    // Any coin that is not credited goes back to the customer, in any state.
    reject_d = (coin_cnt != 2'd0) && !coin_accept;

    unique case (state_q)
      IDLE: begin
        tmo_d    = '0;
        credit_d = credit_q + coin_add;
        if (sel_valid) begin
          sel_d    = diet ? PROD_DIET : PROD_SODA;
          credit_d = credit_q + coin_add - CREDIT_W'(PRICE);
          state_d  = DISPENSE;
        end else if (coin_return && (credit_q != '0)) begin
          state_d = CHG_REQ;
        end
      end

      DISPENSE: begin
        // tmo_q counts completed DISPENSE cycles; the fault fires at the end
        // of cycle number DISP_TIMEOUT. An ack in that same cycle wins.
        tmo_d = tmo_q + TMO_W'(1);
        if (hs.disp_ack) begin
          state_d = (credit_q != '0) ? CHG_REQ : DONE;
        end else if (tmo_q == TMO_W'(DISP_TIMEOUT - 1)) begin
          fault_d  = 1'b1;
          credit_d = credit_q + CREDIT_W'(PRICE);
          state_d  = CHG_REQ;
        end
      end

      CHG_REQ: begin
        // Credit is frozen here, so the picked coin stays stable until ack.
        if (hs.chg_ack) begin
          credit_d = credit_q - pick_val;
          state_d  = CHG_GAP;
        end
      end

      CHG_GAP: begin
        state_d = (credit_q != '0) ? CHG_REQ : DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only, so reset clears them at once.
  assign hs.disp_req = (state_q == DISPENSE);
  assign hs.disp_sel = (state_q == DISPENSE) ? sel_q : 1'b0;
  assign hs.chg_req  = (state_q == CHG_REQ);
  assign hs.chg_coin = (state_q == CHG_REQ) ? pick_coin : COIN_NONE;

  assign credit      = credit_q;
  assign busy        = (state_q != IDLE);
  assign coin_reject = reject_q;
  assign vend_done   = (state_q == DONE);
  assign fault       = fault_q;

endmodule
